// File: rtl/tracking_pkg.sv
// Shared types and width helpers for the object tracker front end and Kalman stage.
package tracking_pkg;

  localparam int DEFAULT_COLOR_WIDTH = 10;
  localparam int DEFAULT_DISP_WIDTH  = 11;

  typedef enum logic [1:0] {
    ACCUM,
    DIVIDE,
    OUTPUT
  } state_e;

  // Coordinate sums need 3x the display width; the match count needs 2x.
  function automatic int sumWidth(input int dispWidth);
    return 3 * dispWidth;
  endfunction

  function automatic int cntWidth(input int dispWidth);
    return 2 * dispWidth;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring serial divider producing one quotient bit per clock, MSB first.
module serial_divider #(
  parameter int DVD_W = 33,
  parameter int DVS_W = 22,
  parameter int QUO_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             done_o,
  output logic [QUO_W-1:0] quotient_o
);

  localparam int ITER_W = $clog2(DVD_W + 1);

  logic [DVD_W-1:0]  dvd_q, dvd_d;
  logic [DVS_W-1:0]  rem_q, rem_d;
  logic [DVS_W-1:0]  dvs_q;
  logic [ITER_W-1:0] iter_q;
  logic              busy_q;
  logic [DVS_W:0]    remShift;
  logic              qBit;
  logic              lastIter;

  // Quotient bits shift into the dividend register as its bits are consumed.
  always_comb begin
    remShift = {rem_q, dvd_q[DVD_W-1]};
    qBit     = (remShift >= {1'b0, dvs_q});
    rem_d    = qBit ? DVS_W'(remShift - {1'b0, dvs_q}) : remShift[DVS_W-1:0];
    dvd_d    = {dvd_q[DVD_W-2:0], qBit};
    lastIter = (iter_q == ITER_W'(DVD_W - 1));
  end

  // done_o and quotient_o reflect the final iteration so the caller can
  // register the result on the same edge the last bit is produced.
  assign done_o     = busy_q && lastIter;
  assign quotient_o = dvd_d[QUO_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      dvd_q  <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
      iter_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      dvd_q  <= dvd_d;
      rem_q  <= rem_d;
      iter_q <= iter_q + ITER_W'(1);
      if (lastIter) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/object_centroid.sv
// Colour-window pixel classifier and per-frame centroid measurement for the tracker.
module object_centroid
  import tracking_pkg::*;
#(
  parameter int COLOR_WIDTH = DEFAULT_COLOR_WIDTH,
  parameter int DISP_WIDTH  = DEFAULT_DISP_WIDTH,
  parameter int MIN_PIXELS  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_valid,
  input  logic [DISP_WIDTH-1:0]  pix_x,
  input  logic [DISP_WIDTH-1:0]  pix_y,
  input  logic [COLOR_WIDTH-1:0] pix_r,
  input  logic [COLOR_WIDTH-1:0] pix_g,
  input  logic [COLOR_WIDTH-1:0] pix_b,
  input  logic                   frame_end,
  input  logic [COLOR_WIDTH-1:0] tgt_r,
  input  logic [COLOR_WIDTH-1:0] tgt_g,
  input  logic [COLOR_WIDTH-1:0] tgt_b,
  input  logic [COLOR_WIDTH-1:0] tol,
  output logic                   meas_valid,
  input  logic                   meas_ready,
  output logic [DISP_WIDTH-1:0]  meas_x,
  output logic [DISP_WIDTH-1:0]  meas_y,
  output logic                   meas_found,
  output logic                   frame_dropped
);

  localparam int SUM_W = sumWidth(DISP_WIDTH);
  localparam int CNT_W = cntWidth(DISP_WIDTH);

  function automatic logic [COLOR_WIDTH-1:0] absDiff(input logic [COLOR_WIDTH-1:0] a,
                                                     input logic [COLOR_WIDTH-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  state_e                 state_q, state_d;
  logic [SUM_W-1:0]       sum_x_q, sum_y_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [SUM_W-1:0]       sumXInc, sumYInc;
  logic [CNT_W-1:0]       cntInc;
  logic                   pixMatch;
  logic                   frameFound;
  logic                   divStart;
  logic                   doneX, doneY;
  logic [DISP_WIDTH-1:0]  quotX, quotY;
  logic                   meas_valid_q, meas_valid_d;
  logic [DISP_WIDTH-1:0]  meas_x_q, meas_x_d;
  logic [DISP_WIDTH-1:0]  meas_y_q, meas_y_d;
  logic                   meas_found_q, meas_found_d;
  logic                   frame_dropped_q, frame_dropped_d;

  // Running sums include the current pixel so a pixel coincident with
  // frame_end lands in the snapshot of the frame it ends.
  always_comb begin
    pixMatch = pix_valid
            && (absDiff(pix_r, tgt_r) <= tol)
            && (absDiff(pix_g, tgt_g) <= tol)
            && (absDiff(pix_b, tgt_b) <= tol);
    sumXInc    = sum_x_q + (pixMatch ? {{(SUM_W-DISP_WIDTH){1'b0}}, pix_x} : '0);
    sumYInc    = sum_y_q + (pixMatch ? {{(SUM_W-DISP_WIDTH){1'b0}}, pix_y} : '0);
    cntInc     = cnt_q + (pixMatch ? CNT_W'(1) : CNT_W'(0));
    frameFound = (cntInc >= CNT_W'(MIN_PIXELS)) && (cntInc != '0);
  end

  // Every frame_end restarts accumulation, whether the frame is kept or dropped.
  always_ff @(posedge clk) begin
    if (reset || frame_end) begin
      sum_x_q <= '0;
      sum_y_q <= '0;
      cnt_q   <= '0;
    end else begin
      sum_x_q <= sumXInc;
      sum_y_q <= sumYInc;
      cnt_q   <= cntInc;
    end
  end

  serial_divider #(
    .DVD_W (SUM_W),
    .DVS_W (CNT_W),
    .QUO_W (DISP_WIDTH)
  ) u_div_x (
    .clk        (clk),
    .reset      (reset),
    .start_i    (divStart),
    .dividend_i (sumXInc),
    .divisor_i  (cntInc),
    .done_o     (doneX),
    .quotient_o (quotX)
  );

  serial_divider #(
    .DVD_W (SUM_W),
    .DVS_W (CNT_W),
    .QUO_W (DISP_WIDTH)
  ) u_div_y (
    .clk        (clk),
    .reset      (reset),
    .start_i    (divStart),
    .dividend_i (sumYInc),
    .divisor_i  (cntInc),
    .done_o     (doneY),
    .quotient_o (quotY)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: begin
        if (frame_end) begin
          state_d = frameFound ? DIVIDE : OUTPUT;
        end
      end
      DIVIDE: begin
        if (doneX && doneY) begin
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (meas_valid_q && meas_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Measurement fields only move when a new result is produced, so they stay
  // stable for the whole time meas_valid is high.
  always_comb begin
    divStart        = (state_q == ACCUM) && frame_end && frameFound;
    meas_valid_d    = (state_d == OUTPUT);
    meas_x_d        = meas_x_q;
    meas_y_d        = meas_y_q;
    meas_found_d    = meas_found_q;
    frame_dropped_d = frame_end && (state_q != ACCUM);
    if ((state_q == ACCUM) && frame_end && !frameFound) begin
      meas_found_d = 1'b0;
    end else if ((state_q == DIVIDE) && doneX && doneY) begin
      meas_x_d     = quotX;
      meas_y_d     = quotY;
      meas_found_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meas_valid_q    <= 1'b0;
      meas_x_q        <= '0;
      meas_y_q        <= '0;
      meas_found_q    <= 1'b0;
      frame_dropped_q <= 1'b0;
    end else begin
      meas_valid_q    <= meas_valid_d;
      meas_x_q        <= meas_x_d;
      meas_y_q        <= meas_y_d;
      meas_found_q    <= meas_found_d;
      frame_dropped_q <= frame_dropped_d;
    end
  end

  assign meas_valid    = meas_valid_q;
  assign meas_x        = meas_x_q;
  assign meas_y        = meas_y_q;
  assign meas_found    = meas_found_q;
  assign frame_dropped = frame_dropped_q;

endmodule

// File: doc/object_centroid.md
# object_centroid

Measurement front end for the object tracker. Consumes the pixel stream, classifies each pixel against a target colour window, and accumulates the coordinate sums and match count over a frame. At frame end it computes the matched-pixel centroid with a serial divider and hands one (x, y) measurement per frame to the Kalman update stage over a valid/ready handshake.

## Interface
- COLOR_WIDTH, 10, bits per colour channel
- DISP_WIDTH, 11, bits per display coordinate
- MIN_PIXELS, 16, minimum match count for a frame to count as "found"
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_valid  in  1  qualifies pix_* this cycle
- pix_x, pix_y  in  DISP_WIDTH  pixel coordinates
- pix_r, pix_g, pix_b  in  COLOR_WIDTH  pixel colour
- frame_end  in  1  single-cycle pulse on or after the frame's last pixel
- tgt_r, tgt_g, tgt_b  in  COLOR_WIDTH  target colour; held quasi-static
- tol  in  COLOR_WIDTH  per-channel match tolerance
- meas_valid  out  1  measurement available
- meas_ready  in  1  downstream accepts the measurement
- meas_x, meas_y  out  DISP_WIDTH  centroid, floor division
- meas_found  out  1  match count >= MIN_PIXELS
- frame_dropped  out  1  single-cycle pulse when a frame result is discarded

## Operation
- Match: pix_valid and |pix_c - tgt_c| <= tol on all three channels. Compute the differences unsigned, with no wrap.
- Accumulators: sum_x and sum_y are SUM_W = 3*DISP_WIDTH bits; count is CNT_W = 2*DISP_WIDTH bits. Overflow cannot occur and there is no saturation.
- A pixel that coincides with frame_end belongs to the ending frame.
- On frame_end in ACCUM:
  - Snapshot sums and count, including a coincident pixel, into the divider registers.
  - Clear the accumulators in the same cycle; the next frame starts at zero.
- FSM states ACCUM, DIVIDE, OUTPUT:
  - ACCUM + frame_end, with count >= MIN_PIXELS and count != 0 -> DIVIDE.
  - ACCUM + frame_end, otherwise -> OUTPUT with meas_found=0. meas_x and meas_y keep their last values.
  - DIVIDE: restoring serial division, x and y in parallel, one quotient bit per cycle, SUM_W iterations -> OUTPUT. The quotient is truncated to DISP_WIDTH, which is exact because the quotient is at most 2^DISP_WIDTH - 1.
  - OUTPUT: meas_valid=1. Leave when meas_valid && meas_ready -> ACCUM.
- Accumulation of the next frame continues during DIVIDE and OUTPUT.
- frame_end while in DIVIDE or OUTPUT:
  - The accumulated frame is discarded: accumulators cleared, frame_dropped pulses.
  - The in-flight measurement is unaffected.
- Reset, including mid-divide: state ACCUM, accumulators and divider cleared, all outputs 0. Any in-progress result is lost.

## Timing
- All outputs are registered.
- Found path: frame_end sampled at edge T; DIVIDE occupies cycles T+1..T+SUM_W (33 at default); meas_valid first high in cycle T+SUM_W+1 (T+34).
- Not-found path: meas_valid high in cycle T+1.
- meas_x, meas_y and meas_found are stable whenever meas_valid=1 and change only on leaving DIVIDE or on the not-found transition.
- Handshake: meas_valid stays high until the cycle meas_ready=1. The transfer completes on that edge, and meas_valid is 0 the next cycle. meas_ready is ignored while meas_valid=0.
- Earliest next result: a frame_end on the handshake cycle itself is a drop. A frame_end one cycle later is accepted.
- frame_dropped is high for exactly the cycle after the offending frame_end.

## Structure
- tracking_pkg holds:
  - FSM state enum (ACCUM, DIVIDE, OUTPUT).
  - SUM_W/CNT_W derivation functions of DISP_WIDTH.
  - Default COLOR_WIDTH/DISP_WIDTH constants shared with the Kalman stage.
- Sub-module serial_divider, parameterised on dividend/divisor/quotient widths:
  - Handshake: start/done.
  - Instantiated twice (x, y), sharing the count as divisor.
- The colour match is inline combinational logic in object_centroid.

## Test plan
- MIN_PIXELS=1; one matching pixel at (100,50); frame_end -> meas_valid at T+34 with (100,50), found=1.
- Matches at (10,10), (11,10), (10,11), (11,11), MIN_PIXELS=4 -> (10,10) (floor of 10.5); found=1.
- Frame with zero matches after a found frame at (100,50) -> meas_valid at T+1, found=0, meas_x/meas_y still (100,50).
- Target colour (512,512,512), tol=8:
  - Pixel (520,504,512) -> counted.
  - Pixel (521,512,512) -> not counted.
- meas_ready held low 200 cycles; second frame_end during OUTPUT -> frame_dropped pulses once; meas_x/meas_y unchanged; the following frame's result is correct.
- reset asserted at T+10 mid-divide -> next cycle all outputs 0, state ACCUM; the next full frame produces the correct centroid.
